// File: rtl/alu_pkg.sv
// Shared types and encodings for the bit-serial ALU datapath.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Arithmetic opsel encodings (mode = MODE_ARITH)
  localparam logic [2:0] OP_TRANSFER = 3'b000;
  localparam logic [2:0] OP_ADD      = 3'b001;
  localparam logic [2:0] OP_SUBM1    = 3'b010;
  localparam logic [2:0] OP_SUB      = 3'b011;
  localparam logic [2:0] OP_DEC      = 3'b100;

  // Logic-op encodings on opsel[1:0] (mode = MODE_LOGIC)
  localparam logic [1:0] LOP_AND  = 2'b00;
  localparam logic [1:0] LOP_OR   = 2'b01;
  localparam logic [1:0] LOP_XOR  = 2'b10;
  localparam logic [1:0] LOP_NOTA = 2'b11;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

endpackage

// File: rtl/serial_bit_alu.sv
// One-bit ALU slice: full adder with operand-B conditioning, or bitwise logic op.
module serial_bit_alu
  import alu_pkg::*;
(
  input  logic       a_bit,
  input  logic       b_bit,
  input  logic       cin,
  input  logic [2:0] opsel,
  input  logic       mode,
  output logic       r_bit,
  output logic       cout
);

  logic b_eff;

  // Select conditioned B bit, then either add or apply the logic function
  always_comb begin
    b_eff = 1'b0;
    r_bit = 1'b0;
    cout  = 1'b0;
    if (opsel[2]) begin
      b_eff = 1'b1;
    end else begin
      unique case (opsel[1:0])
        2'b00:   b_eff = 1'b0;
        2'b01:   b_eff = b_bit;
        default: b_eff = ~b_bit;
      endcase
    end
    if (mode == MODE_ARITH) begin
      r_bit = a_bit ^ b_eff ^ cin;
      cout  = (a_bit & b_eff) | (a_bit & cin) | (b_eff & cin);
    end else begin
      unique case (opsel[1:0])
        LOP_AND:  r_bit = a_bit & b_bit;
        LOP_OR:   r_bit = a_bit | b_bit;
        LOP_XOR:  r_bit = a_bit ^ b_bit;
        LOP_NOTA: r_bit = ~a_bit;
        default:  r_bit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/serial_alu_core.sv
// Bit-serial ALU: latches operands on start, processes one bit per clock
// LSB first, then presents result/cout/zero with a one-cycle done pulse.
module serial_alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opsel,
  input  logic             mode,
  input  logic             Cin_initial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, rs_q, rs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       opsel_q, opsel_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             slice_r, slice_c;

  serial_bit_alu u_slice (
    .a_bit (sa_q[0]),
    .b_bit (sb_q[0]),
    .cin   (carry_q),
    .opsel (opsel_q),
    .mode  (mode_q),
    .r_bit (slice_r),
    .cout  (slice_c)
  );

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      rs_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      opsel_q  <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      rs_q     <= rs_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      opsel_q  <= opsel_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

  // Next-state and datapath updates; outputs latch on the final RUN edge
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    rs_d     = rs_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    opsel_d  = opsel_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          sa_d    = a;
          sb_d    = b;
          opsel_d = opsel;
          mode_d  = mode;
          carry_d = (mode == MODE_ARITH) ? Cin_initial : 1'b0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        rs_d    = {slice_r, rs_q[WIDTH-1:1]};
        carry_d = (mode_q == MODE_ARITH) ? slice_c : 1'b0;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // rs_d already holds the final bit, so result/cout/zero load in the same edge
          state_d  = ST_DONE;
          cnt_d    = '0;
          result_d = rs_d;
          cout_d   = carry_d;
          zero_d   = (rs_d == '0);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_alu_core.sv
// Randomized scoreboard bench for serial_alu_core (WIDTH = 8).
module tb_serial_alu_core;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, start, mode, cin;
  logic [W-1:0] a, b;
  logic [2:0]   opsel;
  logic         busy, done, cout, zero;
  logic [W-1:0] result;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_count = 0;
  exp_t sbq[$];
  exp_t held = '0;
  bit   b2b_en = 1'b0;
  bit   have_prev = 1'b0;
  int   prev_done_cyc = 0;
  logic prev_done = 1'b0;

  serial_alu_core #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .opsel       (opsel),
    .mode        (mode),
    .Cin_initial (cin),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .cout        (cout),
    .zero        (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: whole-word arithmetic from the operation rules
  function automatic exp_t model(input logic [W-1:0] ma, mb, input logic [2:0] op,
                                 input logic m, input logic c);
    exp_t e;
    logic [W:0]   s;
    logic [W-1:0] bp;
    if (m == 1'b0) begin
      if (op == 3'b000)      bp = '0;
      else if (op == 3'b001) bp = mb;
      else if (op[2] == 1'b0) bp = ~mb;
      else                    bp = '1;
      s   = {1'b0, ma} + {1'b0, bp} + {{W{1'b0}}, c};
      e.r = s[W-1:0];
      e.c = s[W];
    end else begin
      case (op[1:0])
        2'b00:   e.r = ma & mb;
        2'b01:   e.r = ma | mb;
        2'b10:   e.r = ma ^ mb;
        default: e.r = ~ma;
      endcase
      e.c = 1'b0;
    end
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop and compare on every done; also checks hold, pulse width, spacing
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) begin
        exp_t e;
        done_count++;
        chk("done_width", {31'd0, prev_done}, 32'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("result", {24'd0, result}, {24'd0, e.r});
          chk("cout", {31'd0, cout}, {31'd0, e.c});
          chk("zero", {31'd0, zero}, {31'd0, e.z});
          held = e;
        end
        if (b2b_en && have_prev) chk("b2b_interval", cyc - prev_done_cyc, W + 2);
        prev_done_cyc = cyc;
        have_prev = 1'b1;
      end else begin
        chk("hold", {23'd0, result, cout, zero}, {23'd0, held.r, held.c, held.z});
      end
    end
    prev_done = done;
  end

  task automatic randomize_inputs();
    a     = W'($urandom);
    b     = W'($urandom);
    opsel = 3'($urandom);
    mode  = 1'($urandom);
    cin   = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [W-1:0] ta, tb, input logic [2:0] top,
                       input logic tm, input logic tc, input bit expect_it);
    wait_idle();
    a = ta; b = tb; opsel = top; mode = tm; cin = tc;
    start = 1'b1;
    if (expect_it) sbq.push_back(model(ta, tb, top, tm, tc));
    @(posedge clk);
    #1;
    start = 1'b0;
    randomize_inputs();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b1;
    randomize_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_outs", {21'd0, done, result, cout, zero}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    issue(8'h5A, 8'h3C, 3'b001, 1'b0, 1'b0, 1'b1);
    issue(8'h5A, 8'h3C, 3'b011, 1'b0, 1'b1, 1'b1);
    issue(8'h00, 8'h01, 3'b011, 1'b0, 1'b1, 1'b1);
    issue(8'h01, 8'h77, 3'b100, 1'b0, 1'b0, 1'b1);
    issue(8'h5A, 8'h3C, 3'b010, 1'b1, 1'b0, 1'b1);
    issue(8'hA5, 8'h00, 3'b111, 1'b1, 1'b1, 1'b1);
    issue(8'hFF, 8'h01, 3'b001, 1'b0, 1'b0, 1'b1);

    // Start pulsed mid-RUN must be ignored
    issue(8'h12, 8'h34, 3'b001, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; opsel = 3'b000; mode = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    // Reset during RUN aborts with no done and cleared outputs
    issue(8'h33, 8'h44, 3'b001, 1'b0, 1'b0, 1'b0);
    n = done_count;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    held = '0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_outs", {21'd0, done, result, cout, zero}, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_count, n);

    // Random single operations
    for (int i = 0; i < 30; i++) begin
      issue(W'($urandom), W'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end

    // Start held high: back-to-back at WIDTH+2 interval
    wait_idle();
    have_prev = 1'b0;
    b2b_en = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      randomize_inputs();
      if (busy === 1'b0) sbq.push_back(model(a, b, opsel, mode, cin));
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    b2b_en = 1'b0;

    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_alu_core.md
# serial_alu_core

Bit-serial ALU datapath directly downstream of `c_selector`. It consumes `opsel`, `mode` and the `Cin_initial` carry that `c_selector` derives from them. On `start` it latches two WIDTH-bit operands and processes one bit per clock, LSB first, through a one-bit ALU slice with a registered carry. It then presents the result, carry-out and zero flag with a one-cycle `done` pulse. It trades the parallel ripple adder for area in the ALU top level.

## Interface
- `WIDTH`, default 8: operand/result width; legal values 2 to 32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request a new operation; sampled only in IDLE.
- `a` in WIDTH: operand A; captured on the accepted start.
- `b` in WIDTH: operand B; captured on the accepted start.
- `opsel` in 3: operation select; captured on the accepted start.
- `mode` in 1: 0 = arithmetic, 1 = logic; captured on the accepted start.
- `Cin_initial` in 1: initial carry from `c_selector`; captured on the accepted start.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse when the result becomes valid.
- `result` out WIDTH: last completed result; held until the next completion.
- `cout` out 1: final carry (arithmetic) or 0 (logic); held like `result`.
- `zero` out 1: `result == 0`; held like `result`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`=1.
  - RUN→DONE after the bit counter reaches WIDTH-1.
  - DONE→IDLE unconditionally.
- Accepted start:
  - Load shift registers `sa`←`a` and `sb`←`b`.
  - Carry register ←`Cin_initial`; bit counter ←0.
  - Latch `opsel` and `mode`.
- Each RUN cycle processes bit `i`:
  - Slice inputs are `sa[0]`, `sb[0]` and `carry`.
  - The result bit shifts into the result shift register MSB; `sa` and `sb` shift right.
  - In arithmetic mode, the slice carry-out updates the carry register.
- Arithmetic (`mode`=0): sum = `a` + `b'` + `Cin_initial` (mod 2^WIDTH), with `b'` per bit:
  - `opsel` 000: `b'` = 0 (transfer A).
  - 001: `b'` = b.
  - 010, 011: `b'` = ~b. Subtract = 011 with `Cin_initial`=1, as supplied by `c_selector`.
  - 1xx: `b'` = 1 (A-1 when `Cin_initial`=0).
- Logic (`mode`=1), selected by `opsel[1:0]`:
  - 00 = AND, 01 = OR, 10 = XOR, 11 = NOT A.
  - `opsel[2]` ignored; carry register forced to 0.
- Entering DONE: `result`, `cout` and `zero` update together from the completed shift register and final carry.
- `start` in RUN or DONE is ignored, not queued.
- Operand, `opsel`, `mode` and `Cin_initial` inputs may change freely after acceptance.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State ← IDLE.
  - `busy`=0, `done`=0, `result`=0, `cout`=0, `zero`=0.
  - Internal shift registers, carry and counter cleared.
- Reset mid-RUN aborts the operation. No `done` pulse and no result update occur; outputs return to reset values.
- Start sampled at edge E0 gives:
  - `busy`=1 after E0.
  - Bits processed at edges E1..E_WIDTH.
  - `done`=1 and new `result`, `cout`, `zero` visible after E_WIDTH.
  - `done` and `busy` both return to 0 after E_WIDTH+1.
- Latency is WIDTH cycles from start edge to `done`. Issue interval is WIDTH+2 cycles; next start is acceptable at edge E_WIDTH+2 earliest.
- `start` held high continuously gives back-to-back operations at the WIDTH+2 interval, each using the inputs present at its own accept edge.
- `done` is never high for more than one cycle. Results never change except after a completion edge or reset.

## Structure
- Shared package `alu_pkg`:
  - FSM state enum.
  - `opsel` encodings (`OP_TRANSFER`, `OP_ADD`, `OP_SUBM1`, `OP_SUB`, `OP_DEC`).
  - Logic-op encodings.
  - `MODE_ARITH`/`MODE_LOGIC` constants.
- One combinational sub-module, `serial_bit_alu`:
  - Inputs: a_bit, b_bit, cin, opsel, mode.
  - Outputs: r_bit, cout.
- Counter width is `$clog2(WIDTH)`. No other hierarchy.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold `rst_n`=0 for 2 cycles with `start`=1 → all outputs 0 and state stays IDLE.
- Add: `a`=0x5A, `b`=0x3C, `opsel`=001, `mode`=0, `Cin_initial`=0 → after 8 cycles `done` pulses; `result`=0x96, `cout`=0, `zero`=0.
- Subtract: `a`=0x5A, `b`=0x3C, `opsel`=011, `Cin_initial`=1 → `result`=0x1E, `cout`=1.
- Borrow: `a`=0x00, `b`=0x01, same subtract setup → `result`=0xFF, `cout`=0.
- Decrement: `a`=0x01, `opsel`=100, `Cin_initial`=0 → `result`=0x00, `zero`=1, `cout`=1.
- Logic XOR: `a`=0x5A, `b`=0x3C, `opsel`=010, `mode`=1 → `result`=0x66, `cout`=0.
- Robustness:
  - Pulse `start` at cycle 3 of RUN → ignored; first result intact.
  - Assert `rst_n`=0 at cycle 4 of RUN → no `done` pulse, outputs 0.
  - Hold `start` high continuously → completions exactly 10 cycles apart.
